// File: rtl/alu_op_sequencer.sv
// Sweeps opcodes 0..15 through an external ALU with latched operands and
// records {valid, flag, result} per opcode in a 16-entry result buffer.
module alu_op_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_r,
  input  logic       alu_e,
  output logic       busy,
  output logic       done,
  output logic [4:0] err_count,
  input  logic [3:0] rd_addr,
  output logic [9:0] rd_data,
  output logic [2:0] dbg_state
);

  // Handshake: start is a level request honoured only in IDLE with abort low;
  // abort cancels any non-IDLE state on the next edge; done is a 1-cycle pulse.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_LOAD = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);

  state_t      state_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [3:0]  op_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  err_q;
  logic [2:0]  wait_cnt_q;
  logic [15:0] valid_q;
  logic [9:0]  rd_data_q;
  logic [8:0]  mem_q [16];
  logic        cap_we;

  // The in-flight opcode is never written when abort hits its CAPTURE cycle.
  assign cap_we = (state_q == CAPTURE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      wait_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              a_q     <= a_in;
              b_q     <= b_in;
              op_q    <= '0;
              valid_q <= '0;
              err_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ISSUE;
            end
          end
          ISSUE: begin
            if (SETTLE > 0) begin
              wait_cnt_q <= WAIT_LOAD;
              state_q    <= WAIT;
            end else begin
              state_q <= CAPTURE;
            end
          end
          WAIT: begin
            if (wait_cnt_q == 3'd0) begin
              state_q <= CAPTURE;
            end else begin
              wait_cnt_q <= wait_cnt_q - 3'd1;
            end
          end
          CAPTURE: begin
            valid_q[op_q] <= 1'b1;
            if (alu_e && err_q != 5'd16) begin
              err_q <= err_q + 5'd1;
            end
            if (op_q == 4'd15) begin
              state_q <= DONE;
            end else begin
              op_q    <= op_q + 4'd1;
              state_q <= ISSUE;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Buffer payload needs no reset: valid_q gates every read.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem_q[op_q] <= {alu_e, alu_r};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (valid_q[rd_addr]) begin
      rd_data_q <= {1'b1, mem_q[rd_addr]};
    end else begin
      rd_data_q <= '0;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign rd_data   = rd_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Runs two sequencers (SETTLE=1 and SETTLE=0) side by side against a simple
// ALU model and compares buffer contents, latency and flags with a scoreboard.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [3:0] rd_addr = '0;

  logic [7:0] alu_a1, alu_b1, alu_r1, alu_a0, alu_b0, alu_r0;
  logic [3:0] alu_op1, alu_op0;
  logic       alu_e1, alu_e0, busy1, busy0, done1, done0;
  logic [4:0] err1, err0;
  logic [9:0] rd_data1, rd_data0;
  logic [2:0] st1, st0;

  logic [9:0] exp_q [$];
  logic [9:0] exp0_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_a = '0;
  logic [7:0] last_b = '0;

  // External ALU model: r = a + b + op, flag = op[3] & op[0].
  assign alu_r1 = alu_a1 + alu_b1 + {4'd0, alu_op1};
  assign alu_e1 = alu_op1[3] & alu_op1[0];
  assign alu_r0 = alu_a0 + alu_b0 + {4'd0, alu_op0};
  assign alu_e0 = alu_op0[3] & alu_op0[0];

  alu_op_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_r(alu_r1), .alu_e(alu_e1), .busy(busy1), .done(done1),
    .err_count(err1), .rd_addr(rd_addr), .rd_data(rd_data1), .dbg_state(st1)
  );

  alu_op_sequencer #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
    .alu_r(alu_r0), .alu_e(alu_e0), .busy(busy0), .done(done0),
    .err_count(err0), .rd_addr(rd_addr), .rd_data(rd_data0), .dbg_state(st0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model_entry(input logic [7:0] a, input logic [7:0] b, input int k);
    logic [7:0] r;
    logic [3:0] op;
    op = 4'(k);
    r  = a + b + {4'd0, op};
    return {1'b1, op[3] & op[0], r};
  endfunction

  // Opcode k finishes if its CAPTURE cycle precedes the cycle abort was driven in.
  function automatic bit op_completed(input int k, input int s, input int abort_at);
    return (abort_at < 0) || (k * (s + 2) + s + 1 < abort_at);
  endfunction

  task automatic push_expected(input logic [7:0] a, input logic [7:0] b, input int abort_at,
                               output int e1, output int e0);
    e1 = 0;
    e0 = 0;
    for (int k = 0; k < 16; k++) begin
      if (op_completed(k, 1, abort_at)) begin
        exp_q.push_back(model_entry(a, b, k));
        if (k[3] & k[0]) e1++;
      end else begin
        exp_q.push_back(10'd0);
      end
      if (op_completed(k, 0, abort_at)) begin
        exp0_q.push_back(model_entry(a, b, k));
        if (k[3] & k[0]) e0++;
      end else begin
        exp0_q.push_back(10'd0);
      end
    end
  endtask

  task automatic read_and_score(input string tag);
    logic [9:0] e;
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      tick();
      if (exp_q.size() == 0 || exp0_q.size() == 0) begin
        check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("%s_s1_entry%0d", tag, k), {22'd0, rd_data1}, {22'd0, e});
        e = exp0_q.pop_front();
        check_eq($sformatf("%s_s0_entry%0d", tag, k), {22'd0, rd_data0}, {22'd0, e});
      end
    end
  endtask

  // Driver: one run with an optional mid-run restart pulse and abort.
  task automatic run_seq(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int restart_at, input int abort_at);
    int lat1, lat0, e1, e0;
    a_in = a;
    b_in = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    last_a = a;
    last_b = b;
    check_eq({tag, "_busy1_start"}, {31'd0, busy1}, 32'd1);
    check_eq({tag, "_busy0_start"}, {31'd0, busy0}, 32'd1);
    lat1 = -1;
    lat0 = -1;
    for (int n = 0; n < 60; n++) begin
      if (n == restart_at) begin
        start = 1'b1;
        a_in = ~a;
        b_in = ~b;
      end
      if (n == restart_at + 1) start = 1'b0;
      if (n == abort_at) abort = 1'b1;
      tick();
      if (n == abort_at) begin
        abort = 1'b0;
        check_eq({tag, "_busy1_after_abort"}, {31'd0, busy1}, 32'd0);
        check_eq({tag, "_busy0_after_abort"}, {31'd0, busy0}, 32'd0);
      end
      if (done1 && lat1 < 0) lat1 = n + 1;
      if (done0 && lat0 < 0) lat0 = n + 1;
    end
    push_expected(a, b, abort_at, e1, e0);
    if (abort_at < 0) begin
      check_eq({tag, "_done_lat_s1"}, lat1, 16 * 3 + 1);
      check_eq({tag, "_done_lat_s0"}, lat0, 16 * 2 + 1);
    end else begin
      check_eq({tag, "_no_done_s1"}, lat1, -1);
      check_eq({tag, "_no_done_s0"}, lat0, -1);
    end
    check_eq({tag, "_err_s1"}, {27'd0, err1}, e1);
    check_eq({tag, "_err_s0"}, {27'd0, err0}, e0);
    check_eq({tag, "_idle_busy1"}, {31'd0, busy1}, 32'd0);
    check_eq({tag, "_alu_a1_hold"}, {24'd0, alu_a1}, {24'd0, a});
    read_and_score(tag);
  endtask

  initial begin
    repeat (2) tick();
    check_eq("rst_busy", {31'd0, busy1}, 32'd0);
    check_eq("rst_done", {31'd0, done1}, 32'd0);
    check_eq("rst_alu", {12'd0, alu_a1, alu_b1, alu_op1}, 32'd0);
    check_eq("rst_err", {27'd0, err1}, 32'd0);
    check_eq("rst_rd", {22'd0, rd_data1}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", {31'd0, busy1 | busy0}, 32'd0);

    run_seq("basic", 8'd225, 8'd200, -1, -1);
    check_eq("basic_alu_op_last", {28'd0, alu_op1}, 32'd15);
    run_seq("restart", 8'd225, 8'd200, 10, -1);

    // start and abort together in IDLE: nothing happens
    a_in = 8'h11;
    b_in = 8'h22;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("sa_busy1", {31'd0, busy1}, 32'd0);
    check_eq("sa_busy0", {31'd0, busy0}, 32'd0);
    tick();
    check_eq("sa_busy1_later", {31'd0, busy1}, 32'd0);
    check_eq("sa_no_latch", {16'd0, alu_a1, alu_b1}, {16'd0, last_a, last_b});

    run_seq("abort", 8'h37, 8'h5A, -1, 16);

    // asynchronous reset in the middle of opcode 9 CAPTURE
    a_in = 8'd9;
    b_in = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    check_eq("rst_mid_state_capture", {29'd0, st1}, 32'd3);
    check_eq("rst_mid_op9", {28'd0, alu_op1}, 32'd9);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_alu", {12'd0, alu_a1, alu_b1, alu_op1}, 32'd0);
    check_eq("rst_mid_busy_done", {30'd0, busy1, done1}, 32'd0);
    check_eq("rst_mid_err", {27'd0, err1}, 32'd0);
    check_eq("rst_mid_rd", {22'd0, rd_data1}, 32'd0);
    check_eq("rst_mid_busy0", {31'd0, busy0}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("rst_release_idle", {30'd0, busy1, busy0}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(10'd0);
      exp0_q.push_back(10'd0);
    end
    read_and_score("rst_invalid");
    run_seq("zero_ops", 8'd0, 8'd0, -1, -1);

    for (int i = 0; i < 2; i++) begin
      run_seq($sformatf("rand%0d", i), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), -1, -1);
    end

    check_eq("queue_drained", exp_q.size() + exp0_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
